// File: rtl/axi_ram_responder.sv
// rtl/axi_ram_responder.sv - AXI3-style RAM slave with independent read and write burst engines.
module axi_ram_responder #(
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
    localparam int AW    = MEM_ADDR_WIDTH;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [31:0] mem [DEPTH];

    function automatic logic burst_ok(input logic [1:0] b);
        return (b == BURST_FIXED) || (b == BURST_INCR);
    endfunction

    // Byte-offset and aliased upper address bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{araddr[31:AW+2], araddr[1:0], awaddr[31:AW+2], awaddr[1:0]};

    // ---------------- read engine ----------------
    logic [0:0]    r_state_q, r_state_d;
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic          rlast_q, rlast_d;
    logic [3:0]    rid_q, rid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [AW-1:0] r_idx_q, r_idx_d;
    logic [3:0]    r_len_q, r_len_d;
    logic [3:0]    r_cnt_q, r_cnt_d;
    logic [1:0]    r_burst_q, r_burst_d;
    logic          r_fetch;
    logic          r_fetch_ok;
    logic [AW-1:0] r_fetch_idx;

    always_comb begin
        r_state_d   = r_state_q;
        arready_d   = arready_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        rid_d       = rid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        r_idx_d     = r_idx_q;
        r_len_d     = r_len_q;
        r_cnt_d     = r_cnt_q;
        r_burst_d   = r_burst_q;
        r_fetch     = 1'b0;
        r_fetch_ok  = 1'b0;
        r_fetch_idx = r_idx_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    r_state_d   = R_DATA;
                    arready_d   = 1'b0;
                    rvalid_d    = 1'b1;
                    rid_d       = arid;
                    r_len_d     = arlen;
                    r_burst_d   = arburst;
                    r_cnt_d     = 4'd0;
                    rlast_d     = (arlen == 4'd0);
                    r_fetch     = 1'b1;
                    r_fetch_ok  = burst_ok(arburst);
                    r_fetch_idx = araddr[AW+1:2];
                    r_idx_d     = araddr[AW+1:2];
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                    end else begin
                        r_fetch     = 1'b1;
                        r_fetch_ok  = burst_ok(r_burst_q);
                        r_fetch_idx = (r_burst_q == BURST_INCR) ? r_idx_q + 1'b1 : r_idx_q;
                        r_idx_d     = r_fetch_idx;
                        r_cnt_d     = r_cnt_q + 4'd1;
                        rlast_d     = ((r_cnt_q + 4'd1) == r_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // Fetch samples the array before this edge's write lands, so a colliding write reads old data.
        if (r_fetch) begin
            rdata_d = r_fetch_ok ? mem[r_fetch_idx] : 32'h0;
            rresp_d = r_fetch_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= 4'd0;
            rdata_q   <= 32'h0;
            rresp_q   <= RESP_OKAY;
            r_idx_q   <= '0;
            r_len_q   <= 4'd0;
            r_cnt_q   <= 4'd0;
            r_burst_q <= BURST_FIXED;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= (r_state_d == R_IDLE) ? 1'b1 : arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_burst_q <= r_burst_d;
        end
    end

    // ---------------- write engine ----------------
    logic [1:0]    w_state_q, w_state_d;
    logic          awready_q, awready_d;
    logic          wready_q, wready_d;
    logic          bvalid_q, bvalid_d;
    logic [3:0]    bid_q, bid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic [3:0]    w_id_q, w_id_d;
    logic [AW-1:0] w_idx_q, w_idx_d;
    logic [3:0]    w_len_q, w_len_d;
    logic [3:0]    w_cnt_q, w_cnt_d;
    logic [1:0]    w_burst_q, w_burst_d;
    logic          w_err_q, w_err_d;
    logic          w_beat_last;
    logic          w_beat_err;
    logic          mem_we;

    always_comb begin
        w_state_d   = w_state_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        w_id_d      = w_id_q;
        w_idx_d     = w_idx_q;
        w_len_d     = w_len_q;
        w_cnt_d     = w_cnt_q;
        w_burst_d   = w_burst_q;
        w_err_d     = w_err_q;
        w_beat_last = (w_cnt_q == w_len_q);
        w_beat_err  = (wlast != w_beat_last) || (wid != w_id_q);
        mem_we      = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    w_state_d = W_DATA;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_id_d    = awid;
                    w_idx_d   = awaddr[AW+1:2];
                    w_len_d   = awlen;
                    w_burst_d = awburst;
                    w_cnt_d   = 4'd0;
                    w_err_d   = 1'b0;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    mem_we = burst_ok(w_burst_q);
                    // Beat count, not wlast, decides where the burst ends.
                    if (w_beat_last) begin
                        w_state_d = W_RESP;
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bid_d     = w_id_q;
                        bresp_d   = (w_err_q || w_beat_err || !burst_ok(w_burst_q)) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        w_cnt_d = w_cnt_q + 4'd1;
                        w_err_d = w_err_q || w_beat_err;
                        w_idx_d = (w_burst_q == BURST_INCR) ? w_idx_q + 1'b1 : w_idx_q;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= 4'd0;
            bresp_q   <= RESP_OKAY;
            w_id_q    <= 4'd0;
            w_idx_q   <= '0;
            w_len_q   <= 4'd0;
            w_cnt_q   <= 4'd0;
            w_burst_q <= BURST_FIXED;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= (w_state_d == W_IDLE) ? 1'b1 : awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[w_idx_q][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
endmodule

// File: tb/tb_axi_ram_responder.sv
// tb/tb_axi_ram_responder.sv - Self-checking bench for axi_ram_responder against a word-array model.
module tb_axi_ram_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [3:0]  arlen = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [3:0]  awlen = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [3:0]  wid = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;

    axi_ram_responder #(.MEM_ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;
    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bresp_t;

    logic [31:0] model [1024];
    rbeat_t      rq[$];
    bresp_t      bq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_rbeats = 0;
    int          aw_hs_cyc = 0;
    int          ar_hs_cyc = 0;
    logic [31:0] last_rdata = '0;
    logic [1:0]  last_rresp = '0;
    logic        last_rlast = 1'b0;
    logic [3:0]  last_bid = '0;
    logic [1:0]  last_bresp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a, input int i, input logic [1:0] burst);
        if (burst == 2'b01) return int'(((a >> 2) + 32'(i)) & 32'h3FF);
        return int'((a >> 2) & 32'h3FF);
    endfunction

    function automatic logic legal(input logic [1:0] burst);
        return (burst == 2'b00) || (burst == 2'b01);
    endfunction

    // Compare process: every valid output beat is checked against the model's queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (rvalid) begin
                if (rq.size() == 0) begin
                    check("r_unexpected", 32'(rvalid), 32'd0);
                end else begin
                    check("rid", 32'(rid), 32'(rq[0].id));
                    check("rdata", rdata, rq[0].data);
                    check("rresp", 32'(rresp), 32'(rq[0].resp));
                    check("rlast", 32'(rlast), 32'(rq[0].last));
                    if (rready) begin
                        void'(rq.pop_front());
                        n_rbeats++;
                        last_rdata = rdata;
                        last_rresp = rresp;
                        last_rlast = rlast;
                    end
                end
            end
            if (bvalid) begin
                if (bq.size() == 0) begin
                    check("b_unexpected", 32'(bvalid), 32'd0);
                end else begin
                    check("bid", 32'(bid), 32'(bq[0].id));
                    check("bresp", 32'(bresp), 32'(bq[0].resp));
                    if (bready) begin
                        void'(bq.pop_front());
                        last_bid = bid;
                        last_bresp = bresp;
                    end
                end
            end
        end
    end

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [31:0] base, input logic [3:0] strb,
                            input int wlast_at, input logic [3:0] wid_v);
        logic err;
        int   n;
        int   idx;
        logic exp_last;
        err = !legal(burst) || (wid_v != id);
        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        @(negedge clk);
        for (n = 0; n < 20 && awready !== 1'b1; n++) @(negedge clk);
        if (awready !== 1'b1) begin
            check("aw_timeout", 32'(awready), 32'd1);
            awvalid = 1'b0;
            return;
        end
        aw_hs_cyc = cyc;
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            exp_last = (i == int'(len));
            wvalid = 1'b1; wdata = base + 32'(i); wstrb = strb; wid = wid_v;
            wlast  = (wlast_at < 0) ? exp_last : (i == wlast_at);
            if (wlast != exp_last) err = 1'b1;
            @(negedge clk);
            for (n = 0; n < 20 && wready !== 1'b1; n++) @(negedge clk);
            if (wready !== 1'b1) begin
                check("w_timeout", 32'(wready), 32'd1);
                wvalid = 1'b0;
                return;
            end
            @(posedge clk);
            if (legal(burst)) begin
                idx = word_of(addr, i, burst);
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
            end
            #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        bq.push_back('{id: id, resp: (err ? 2'b10 : 2'b00)});
        for (n = 0; n < 40 && bq.size() != 0; n++) @(posedge clk);
        if (bq.size() != 0) begin
            check("b_timeout", 32'(bq.size()), 32'd0);
            bq.delete();
        end
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [15:0] rpat, input int pre,
                           output int cycles);
        int n;
        int k;
        cycles = 0;
        @(posedge clk);
        repeat (pre) @(posedge clk);
        #1;
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        @(negedge clk);
        for (n = 0; n < 20 && arready !== 1'b1; n++) @(negedge clk);
        if (arready !== 1'b1) begin
            check("ar_timeout", 32'(arready), 32'd1);
            arvalid = 1'b0;
            return;
        end
        for (int i = 0; i <= int'(len); i++)
            rq.push_back('{id: id,
                           data: (legal(burst) ? model[word_of(addr, i, burst)] : 32'h0),
                           resp: (legal(burst) ? 2'b00 : 2'b10),
                           last: (i == int'(len))});
        ar_hs_cyc = cyc;
        @(posedge clk); #1;
        arvalid = 1'b0;
        k = 0;
        while (rq.size() != 0 && k < 64) begin
            rready = (k < 16) ? rpat[k] : 1'b1;
            @(posedge clk); #1;
            k++;
        end
        cycles = k;
        rready = 1'b1;
        if (rq.size() != 0) begin
            check("r_timeout", 32'(rq.size()), 32'd0);
            rq.delete();
        end
    endtask

    int c;
    int b0;

    initial begin
        for (int i = 0; i < 1024; i++) model[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rid_rresp_bid_bresp", 32'({rid, rresp, bid, bresp}), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_arready", 32'(arready), 32'd1);
        check("post_rst_awready", 32'(awready), 32'd1);

        // Four-beat INCR write then read back
        do_write(4'd3, 32'h40, 4'd3, 2'b01, 32'hA0, 4'hF, -1, 4'd3);
        check("wr4_bid", 32'(last_bid), 32'd3);
        check("wr4_bresp", 32'(last_bresp), 32'd0);
        check("model_pin_w16", model[16], 32'hA0);
        b0 = n_rbeats;
        do_read(4'd3, 32'h40, 4'd3, 2'b01, 16'hFFFF, 0, c);
        check("rd4_cycles", 32'(c), 32'd4);
        check("rd4_beats", 32'(n_rbeats - b0), 32'd4);
        check("rd4_last_data", last_rdata, 32'hA3);
        check("rd4_rlast", 32'(last_rlast), 32'd1);

        // Byte strobes merge into existing data
        do_write(4'd1, 32'h0, 4'd0, 2'b01, 32'h11223344, 4'hF, -1, 4'd1);
        do_write(4'd1, 32'h0, 4'd0, 2'b01, 32'hAABBCCDD, 4'b0101, -1, 4'd1);
        do_read(4'd1, 32'h0, 4'd0, 2'b01, 16'hFFFF, 0, c);
        check("strb_merge", last_rdata, 32'h11BB33DD);

        // Back-pressure: rready 1,0,0,1 on a two-beat read
        do_write(4'd2, 32'h200, 4'd1, 2'b01, 32'h5000, 4'hF, -1, 4'd2);
        b0 = n_rbeats;
        do_read(4'd2, 32'h200, 4'd1, 2'b01, 16'hFFF9, 0, c);
        check("stall_beats", 32'(n_rbeats - b0), 32'd2);
        check("stall_cycles", 32'(c), 32'd4);
        check("stall_last_data", last_rdata, 32'h5001);
        @(posedge clk); #1;
        check("stall_rvalid_after", 32'(rvalid), 32'd0);

        // WRAP write is dropped; reserved read returns SLVERR
        do_write(4'd2, 32'h40, 4'd0, 2'b10, 32'hDEAD, 4'hF, -1, 4'd2);
        check("wrap_bresp", 32'(last_bresp), 32'd2);
        do_read(4'd2, 32'h40, 4'd0, 2'b01, 16'hFFFF, 0, c);
        check("wrap_mem_unchanged", last_rdata, 32'hA0);
        do_read(4'd5, 32'h40, 4'd0, 2'b11, 16'hFFFF, 0, c);
        check("rsvd_rdata", last_rdata, 32'h0);
        check("rsvd_rresp", 32'(last_rresp), 32'd2);
        check("rsvd_rlast", 32'(last_rlast), 32'd1);

        // Early wlast: all three beats still accepted, SLVERR
        do_write(4'd4, 32'h300, 4'd2, 2'b01, 32'h77, 4'hF, 0, 4'd4);
        check("early_wlast_bresp", 32'(last_bresp), 32'd2);
        do_read(4'd4, 32'h300, 4'd2, 2'b01, 16'hFFFF, 0, c);
        check("early_wlast_data", last_rdata, 32'h79);

        // wid mismatch
        do_write(4'd6, 32'h310, 4'd0, 2'b01, 32'h1234, 4'hF, -1, 4'd7);
        check("wid_bresp", 32'(last_bresp), 32'd2);
        check("wid_bid", 32'(last_bid), 32'd6);

        // FIXED burst hits one word
        do_write(4'd1, 32'h320, 4'd2, 2'b00, 32'h900, 4'hF, -1, 4'd1);
        do_read(4'd1, 32'h320, 4'd1, 2'b00, 16'hFFFF, 0, c);
        check("fixed_data", last_rdata, 32'h902);

        // INCR wraps modulo memory size; upper address bits alias
        do_write(4'd0, 32'hFFC, 4'd1, 2'b01, 32'hC0, 4'hF, -1, 4'd0);
        do_read(4'd0, 32'h0, 4'd0, 2'b01, 16'hFFFF, 0, c);
        check("wrap_mod_word0", last_rdata, 32'hC1);
        do_read(4'd0, 32'h1000, 4'd0, 2'b01, 16'hFFFF, 0, c);
        check("alias_word0", last_rdata, 32'hC1);

        // Read fetch colliding with a write beat returns old data
        do_write(4'd8, 32'h330, 4'd0, 2'b01, 32'h55, 4'hF, -1, 4'd8);
        fork
            do_write(4'd8, 32'h330, 4'd0, 2'b01, 32'h66, 4'hF, -1, 4'd8);
            do_read(4'd9, 32'h330, 4'd0, 2'b01, 16'hFFFF, 1, c);
        join
        check("collide_old_data", last_rdata, 32'h55);
        do_read(4'd9, 32'h330, 4'd0, 2'b01, 16'hFFFF, 0, c);
        check("collide_new_data", last_rdata, 32'h66);

        // AR and AW handshakes in the same cycle
        fork
            do_write(4'd10, 32'h340, 4'd1, 2'b01, 32'hE0, 4'hF, -1, 4'd10);
            do_read(4'd11, 32'h40, 4'd3, 2'b01, 16'hFFFF, 0, c);
        join
        check("same_cycle_ar_aw", 32'(ar_hs_cyc), 32'(aw_hs_cyc));

        // Reset during the second beat of a read
        @(posedge clk); #1;
        arid = 4'd2; araddr = 32'h40; arlen = 4'd3; arburst = 2'b01; arvalid = 1'b1;
        @(negedge clk);
        check("rstmid_arready", 32'(arready), 32'd1);
        for (int i = 0; i < 4; i++)
            rq.push_back('{id: 4'd2, data: model[word_of(32'h40, i, 2'b01)], resp: 2'b00, last: (i == 3)});
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(posedge clk); #2;
        check("rstmid_rvalid_before", 32'(rvalid), 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid_rvalid", 32'(rvalid), 32'd0);
        check("rstmid_arready_in_rst", 32'(arready), 32'd0);
        rq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("rstmid_arready_after", 32'(arready), 32'd1);
        check("rstmid_rvalid_after", 32'(rvalid), 32'd0);
        do_read(4'd2, 32'h44, 4'd0, 2'b01, 16'hFFFF, 0, c);
        check("mem_kept_over_rst", last_rdata, 32'hA1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
